// File: rtl/uart_io.sv
`timescale 1ns/1ps
// uart_io: byte-level UART I/O unit between the exec stage and the board pins.
//
// Write path: uart_wenable latches uart_wd[7:0]; the byte is pushed into the
// TX FIFO as soon as there is room, with a one-cycle uart_wdone pulse. A TX FSM
// pops bytes and serializes them onto txd as 8N1 frames, back-to-back.
// Read path: rxd is synchronized and deserialized into the RX FIFO. uart_renable
// arms a pending read that completes (uart_rdone, uart_rd = {24'h0, byte}) as
// soon as the RX FIFO holds a byte.
//
// Parameters:
//   CLK_PER_BIT  clock cycles per UART bit (>= 4)
//   FIFO_LOG2    log2 of each FIFO depth
// Ports:
//   clk, rstn                   clock, synchronous active-low reset
//   uart_wenable/uart_wd        write request and data (only [7:0] sent)
//   uart_wdone                  pulse: byte accepted into TX FIFO
//   uart_renable                read request
//   uart_rd/uart_rdone          read data and completion pulse
//   txd/rxd                     serial out (idle high) / serial in (async)
//   rx_overrun, rx_frame_err    sticky RX error flags
// Build option:
//   UART_LOOPBACK_EN  when defined, RX listens to the internal txd and rxd is ignored.

module uart_io_fifo #(
    parameter int FIFO_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] PTR_ONE = 1;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_LOG2:0] wptr;
    logic [FIFO_LOG2:0] rptr;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[FIFO_LOG2] != rptr[FIFO_LOG2]) &&
                      (wptr[FIFO_LOG2-1:0] == rptr[FIFO_LOG2-1:0]);
    assign pop_data = mem[rptr[FIFO_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[FIFO_LOG2-1:0]] <= push_data;
    end
endmodule

module uart_io #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_LOG2   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_wenable,
    input  logic [31:0] uart_wd,
    output logic        uart_wdone,
    input  logic        uart_renable,
    output logic [31:0] uart_rd,
    output logic        uart_rdone,
    output logic        txd,
    input  logic        rxd,
    output logic        rx_overrun,
    output logic        rx_frame_err
);
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Upper write-data bits are never transmitted.
    logic wd_unused;
    assign wd_unused = ^uart_wd[31:8];

    // ---------------- write path ----------------
    logic       wr_pend;
    logic [7:0] wr_data;
    logic       wr_go;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_pop;
    logic [7:0] tx_pop_data;
    logic [7:0] tx_push_data;

    // A request arriving with room in the FIFO goes straight in, so wdone
    // follows wenable by one cycle; otherwise it waits in wr_data.
    assign wr_go        = (wr_pend || uart_wenable) && !tx_full;
    assign tx_push_data = wr_pend ? wr_data : uart_wd[7:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_pend    <= 1'b0;
            uart_wdone <= 1'b0;
        end else begin
            uart_wdone <= wr_go;
            if (wr_go)             wr_pend <= 1'b0;
            else if (uart_wenable) wr_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (uart_wenable && !wr_pend) wr_data <= uart_wd[7:0];
    end

    uart_io_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_tx_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (wr_go),
        .push_data(tx_push_data),
        .pop      (tx_pop),
        .pop_data (tx_pop_data),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    // ---------------- TX FSM ----------------
    state_t           tx_state;
    state_t           tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_tick;
    logic             txd_next;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            S_IDLE:  if (!tx_empty) begin
                         tx_next = S_START;
                         tx_pop  = 1'b1;
                     end
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
            // Chain straight into the next frame when a byte is waiting.
            S_STOP:  if (tx_tick) begin
                         if (!tx_empty) begin
                             tx_next = S_START;
                             tx_pop  = 1'b1;
                         end else begin
                             tx_next = S_IDLE;
                         end
                     end
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        txd_next = 1'b1;
        case (tx_state)
            S_START: txd_next = 1'b0;
            S_DATA:  txd_next = tx_shift[0];
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            txd    <= 1'b1;
            tx_cnt <= '0;
            tx_bit <= '0;
        end else begin
            txd <= txd_next;
            if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
            else                               tx_cnt <= tx_cnt + CNT_ONE;
            if (tx_pop)                            tx_bit <= '0;
            else if (tx_state == S_DATA && tx_tick) tx_bit <= tx_bit + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop)                             tx_shift <= tx_pop_data;
        else if (tx_state == S_DATA && tx_tick) tx_shift <= {1'b0, tx_shift[7:1]};
    end

    // ---------------- RX synchronizer ----------------
    logic rx_src;
`ifdef UART_LOOPBACK_EN
    logic rxd_unused;
    assign rxd_unused = rxd;
    assign rx_src     = txd;
`else
    assign rx_src = rxd;
`endif

    logic rx_s1;
    logic rx_s2;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_src;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;

    // ---------------- RX FSM ----------------
    state_t           rx_state;
    state_t           rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_tick;
    logic             rx_half;
    logic             rx_clr;
    logic             rx_push;
    logic             ovr_set;
    logic             ferr_set;
    logic             rx_full;
    logic             rx_empty;
    logic [7:0]       rx_pop_data;
    logic             rd_go;

    assign rx_tick = (rx_cnt == BIT_LAST);
    assign rx_half = (rx_cnt == HALF_LAST);
    // START only runs half a bit so later samples land at bit centres.
    assign rx_clr  = (rx_state == S_IDLE) ||
                     ((rx_state == S_START) ? rx_half : rx_tick);

    always_ff @(posedge clk) begin
        if (!rstn) rx_state <= S_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_half) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
            // Leave at the stop-bit centre so a following start edge is caught.
            S_STOP:  if (rx_tick) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_push  = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        if (rx_state == S_STOP && rx_tick) begin
            rx_push  = rx_s2 && !rx_full;
            ovr_set  = rx_s2 && rx_full;
            ferr_set = !rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_clr) rx_cnt <= '0;
            else        rx_cnt <= rx_cnt + CNT_ONE;
            if (rx_state != S_DATA) rx_bit <= '0;
            else if (rx_tick)       rx_bit <= rx_bit + 3'd1;
            if (ovr_set)  rx_overrun   <= 1'b1;
            if (ferr_set) rx_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[7:1]};
    end

    uart_io_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_rx_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (rx_push),
        .push_data(rx_shift),
        .pop      (rd_go),
        .pop_data (rx_pop_data),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    // ---------------- read path ----------------
    logic rd_pend;

    // A read waits here until a byte is available; no timeout.
    assign rd_go = (rd_pend || uart_renable) && !rx_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_pend    <= 1'b0;
            uart_rdone <= 1'b0;
            uart_rd    <= '0;
        end else begin
            uart_rdone <= rd_go;
            if (rd_go) uart_rd <= {24'h0, rx_pop_data};
            if (rd_go)             rd_pend <= 1'b0;
            else if (uart_renable) rd_pend <= 1'b1;
        end
    end
endmodule
